// File: rtl/aes_pkg.sv
// Shared widths and FSM encoding for the AES request scheduler.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W = 128;
  localparam int unsigned AES_KEY_W   = 128;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sched_state_t;

endpackage

// File: rtl/aes_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after the pointer.
module aes_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_winner_oh,
  output logic [ID_W-1:0]    o_winner_idx,
  output logic               o_any_valid
);

  int w_idx;

  always_comb begin
    w_idx        = 0;
    o_winner_oh  = '0;
    o_winner_idx = '0;
    o_any_valid  = |i_req_valid;
    // Walk from the farthest slot back to ptr so the nearest valid slot is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = (int'(i_ptr) + k) % int'(NUM_REQ);
      if (i_req_valid[w_idx]) begin
        o_winner_oh         = '0;
        o_winner_oh[w_idx]  = 1'b1;
        o_winner_idx        = ID_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/aes_req_scheduler.sv
// Shares one iterative AES-128 core between NUM_REQ requesters: round-robin accept,
// one-cycle start pulse, watchdog-guarded wait, ID-tagged response.
module aes_req_scheduler
  import aes_pkg::*;
#(
  parameter int unsigned  NUM_REQ = 4,
  parameter int unsigned  TIMEOUT = 15,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [0:NUM_REQ*AES_KEY_W-1] req_key,
  input  logic [0:NUM_REQ*AES_BLOCK_W-1] req_data,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [ID_W-1:0]              resp_id,
  output logic [0:AES_BLOCK_W-1]       resp_cipher,
  output logic                         resp_err,
  output logic                         core_start,
  output logic [0:AES_KEY_W-1]         core_key,
  output logic [0:AES_BLOCK_W-1]       core_data,
  input  logic                         core_done,
  input  logic [0:AES_BLOCK_W-1]       core_cipher,
  output logic                         busy
);

  localparam int unsigned WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  sched_state_t r_state, w_state_next;

  logic [ID_W-1:0]        r_ptr;
  logic [ID_W-1:0]        r_id;
  logic [0:AES_KEY_W-1]   r_key;
  logic [0:AES_BLOCK_W-1] r_data;
  logic [WDOG_W-1:0]      r_wdog;
  logic [0:AES_BLOCK_W-1] r_resp_cipher;
  logic                   r_resp_err;

  logic [NUM_REQ-1:0] w_winner_oh;
  logic [ID_W-1:0]    w_winner_idx;
  logic               w_any_valid;
  logic               w_accept;
  logic               w_wdog_expired;

  aes_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .i_req_valid  (req_valid),
    .i_ptr        (r_ptr),
    .o_winner_oh  (w_winner_oh),
    .o_winner_idx (w_winner_idx),
    .o_any_valid  (w_any_valid)
  );

  assign w_accept       = (r_state == IDLE) && w_any_valid;
  assign w_wdog_expired = (r_wdog == WDOG_W'(TIMEOUT));

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any_valid) w_state_next = ISSUE;
      ISSUE:   w_state_next = WAIT;
      WAIT:    if (core_done || w_wdog_expired) w_state_next = RESP;
      RESP:    if (resp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_id          <= '0;
      r_key         <= '0;
      r_data        <= '0;
      r_wdog        <= '0;
      r_resp_cipher <= '0;
      r_resp_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_key  <= req_key[32'(w_winner_idx) * AES_KEY_W +: AES_KEY_W];
        r_data <= req_data[32'(w_winner_idx) * AES_BLOCK_W +: AES_BLOCK_W];
        r_id   <= w_winner_idx;
        r_ptr  <= (w_winner_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_winner_idx + 1'b1;
      end
      if (r_state == ISSUE) begin
        r_wdog <= '0;
      end
      // Done takes priority over an expiring watchdog in the same cycle.
      if (r_state == WAIT) begin
        if (core_done) begin
          r_resp_cipher <= core_cipher;
          r_resp_err    <= 1'b0;
        end else if (w_wdog_expired) begin
          r_resp_cipher <= '0;
          r_resp_err    <= 1'b1;
        end else begin
          r_wdog <= r_wdog + 1'b1;
        end
      end
    end
  end

  assign req_ready   = (r_state == IDLE) ? w_winner_oh : '0;
  assign core_start  = (r_state == ISSUE);
  assign core_key    = r_key;
  assign core_data   = r_data;
  assign resp_valid  = (r_state == RESP);
  assign resp_id     = r_id;
  assign resp_cipher = r_resp_cipher;
  assign resp_err    = r_resp_err;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Randomised bench for aes_req_scheduler against a transaction-timeline reference model
// and a behavioural AES-128 core with programmable latency.
module tb_aes_req_scheduler;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 15;
  localparam int ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [0:NUM_REQ*128-1]    req_key;
  logic [0:NUM_REQ*128-1]    req_data;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [ID_W-1:0]           resp_id;
  logic [0:127]              resp_cipher;
  logic                      resp_err;
  logic                      core_start;
  logic [0:127]              core_key;
  logic [0:127]              core_data;
  logic                      core_done;
  logic [0:127]              core_cipher;
  logic                      busy;

  always #5 clk = ~clk;

  aes_req_scheduler #(
    .NUM_REQ (NUM_REQ),
    .TIMEOUT (TIMEOUT)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_key     (req_key),
    .req_data    (req_data),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_cipher (resp_cipher),
    .resp_err    (resp_err),
    .core_start  (core_start),
    .core_key    (core_key),
    .core_data   (core_data),
    .core_done   (core_done),
    .core_cipher (core_cipher),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural AES-128
  logic [7:0] sb [256];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic init_sbox();
    logic [7:0] p;
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      p   = 8'(x);
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin  // x^254 = multiplicative inverse
        p   = gmul(p, p);
        inv = gmul(inv, p);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [0:127] aes_enc(input logic [0:127] key, input logic [0:127] pt);
    logic [7:0]   rk [176];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3, rc;
    logic [0:127] out;
    for (int i = 0; i < 16; i++) begin
      rk[i] = key[i*8 +: 8];
      s[i]  = pt[i*8 +: 8] ^ key[i*8 +: 8];
    end
    rc = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      a0 = rk[i-4]; a1 = rk[i-3]; a2 = rk[i-2]; a3 = rk[i-1];
      if (i % 16 == 0) begin
        {a0, a1, a2, a3} = {sb[a1] ^ rc, sb[a2], sb[a3], sb[a0]};
        rc = xtime(rc);
      end
      rk[i] = rk[i-16] ^ a0; rk[i+1] = rk[i-15] ^ a1;
      rk[i+2] = rk[i-14] ^ a2; rk[i+3] = rk[i-13] ^ a3;
    end
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) s[q + 4*c] = t[q + 4*((c + q) % 4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
          s[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= rk[16*r + i];
    end
    for (int i = 0; i < 16; i++) out[i*8 +: 8] = s[i];
    return out;
  endfunction

  // Core model: done rises core_delay cycles after the start edge and stays up until next start
  int unsigned  core_delay = 1;
  int unsigned  core_cnt;
  logic         core_run;
  logic [0:127] core_res;
  logic [0:127] core_junk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_run  <= 1'b0;
      core_cnt  <= 0;
      core_res  <= '0;
      core_junk <= '0;
    end else begin
      core_junk <= {$urandom, $urandom, $urandom, $urandom};
      if (core_start) begin
        core_run <= 1'b1;
        core_cnt <= 1;
        core_res <= aes_enc(core_key, core_data);
      end else if (core_run && core_cnt < 100000) begin
        core_cnt <= core_cnt + 1;
      end
    end
  end

  assign core_done   = core_run && (core_cnt >= core_delay);
  assign core_cipher = core_done ? core_res : core_junk;

  // Reference model: one transaction timeline at a time
  int           cyc;
  bit           m_fl;
  int           m_ptr;
  int           m_acc_cyc;
  int           m_resp_cyc;
  int           m_id;
  bit           m_err;
  logic [0:127] m_key, m_data, m_cipher;
  int           next_delay;
  bit           rand_mode;
  int           n_starts;
  int           grants [$];
  logic [127:0] log_cipher [$];
  int           log_id [$];
  bit           log_err [$];

  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return TIMEOUT + 1;
    if (r == 1) return TIMEOUT + 2;
    if (r == 2) return 1000;
    return int'($urandom_range(1, 6));
  endfunction

  task automatic step();
    int                 win;
    int                 idx;
    int                 d;
    bit                 rv;
    logic [NUM_REQ-1:0] exp_ready;
    @(negedge clk);
    win       = -1;
    exp_ready = '0;
    if (!m_fl) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (m_ptr + k) % NUM_REQ;
        if (win < 0 && req_valid[idx]) win = idx;
      end
    end
    if (win >= 0) exp_ready[win] = 1'b1;
    rv = m_fl && (cyc >= m_resp_cyc);
    if (core_start) n_starts++;
    check("req_ready", req_ready, exp_ready);
    check("busy", busy, m_fl);
    check("core_start", core_start, m_fl && (cyc == m_acc_cyc + 1));
    check("resp_valid", resp_valid, rv);
    if (m_fl) begin
      check("core_key", core_key, m_key);
      check("core_data", core_data, m_data);
    end
    if (rv) begin
      check("resp_id", resp_id, m_id);
      check("resp_cipher", resp_cipher, m_cipher);
      check("resp_err", resp_err, m_err);
    end
    if (!m_fl && win >= 0) begin
      m_fl       = 1'b1;
      m_acc_cyc  = cyc;
      m_id       = win;
      m_key      = req_key[win*128 +: 128];
      m_data     = req_data[win*128 +: 128];
      m_ptr      = (win + 1) % NUM_REQ;
      d          = rand_mode ? pick_delay() : next_delay;
      core_delay = d;
      if (d <= TIMEOUT + 1) begin
        m_resp_cyc = cyc + 2 + d;
        m_err      = 1'b0;
        m_cipher   = aes_enc(m_key, m_data);
      end else begin
        m_resp_cyc = cyc + TIMEOUT + 3;
        m_err      = 1'b1;
        m_cipher   = '0;
      end
      grants.push_back(win);
    end else if (rv && resp_ready) begin
      m_fl = 1'b0;
      log_cipher.push_back(resp_cipher);
      log_id.push_back(int'(resp_id));
      log_err.push_back(resp_err);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rand_mode) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        req_valid[i] = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 3) == 0) req_key[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 3) == 0) req_data[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
      end
      resp_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic drain(input int budget);
    req_valid  = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < budget && m_fl; i++) step();
    if (m_fl) check("drain_bound", busy, 1'b0);
  endtask

  task automatic single(input logic [NUM_REQ-1:0] v, input int d);
    req_valid  = v;
    next_delay = d;
    step();
    req_valid = '0;
    drain(60);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int guard;
    int exp_g [5] = '{0, 1, 2, 3, 0};
    init_sbox();
    reset_n    = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b1;
    req_key    = '0;
    req_data   = '0;
    rand_mode  = 1'b0;
    m_fl       = 1'b0;
    m_ptr      = 0;
    cyc        = 0;
    n_starts   = 0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_core_start", core_start, 1'b0);
    check("rst_resp_cipher", resp_cipher, '0);
    check("rst_core_key", core_key, '0);
    check("rst_req_ready", req_ready, '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_key[i*128 +: 128]  = {$urandom, $urandom, $urandom, $urandom};
      req_data[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    end

    // All requesters continuously valid: strict rotation from pointer 0
    req_valid  = '1;
    next_delay = 2;
    guard      = 0;
    while (grants.size() < 6 && guard < 300) begin step(); guard++; end
    if (grants.size() < 6) check("rr_bound", grants.size(), 6);
    else for (int i = 0; i < 5; i++) check("rr_order", grants[i], exp_g[i]);
    req_valid = 4'b1010;
    guard     = 0;
    while (grants.size() < 7 && guard < 100) begin step(); guard++; end
    if (grants.size() < 7) check("rr_skip_bound", grants.size(), 7);
    else check("rr_skip_to_3", grants[6], 3);
    drain(60);

    // FIPS-197 Appendix B vector on requester 2
    req_key[2*128 +: 128]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    req_data[2*128 +: 128] = 128'h3243f6a8885a308d313198a2e0370734;
    log_cipher.delete(); log_id.delete(); log_err.delete();
    n_starts = 0;
    single(4'b0100, 5);
    check("fips_starts", n_starts, 1);
    if (log_cipher.size() == 0) check("fips_resp_seen", log_cipher.size(), 1);
    else begin
      check("fips_cipher", log_cipher[0], 128'h3925841d02dc09fbdc118597196a0b32);
      check("fips_id", log_id[0], 2);
      check("fips_err", log_err[0], 1'b0);
    end

    // Back-pressure: response held for several cycles
    resp_ready = 1'b0;
    req_valid  = 4'b0001;
    next_delay = 3;
    step();
    req_valid = '0;
    guard     = 0;
    while (!(m_fl && cyc >= m_resp_cyc) && guard < 40) begin step(); guard++; end
    for (int i = 0; i < 5; i++) step();
    drain(10);
    step();

    // Watchdog expiry, recovery, and done coinciding with the last watchdog cycle
    log_err.delete(); log_cipher.delete();
    single(4'b0010, 1000);
    single(4'b0100, 4);
    single(4'b1000, TIMEOUT + 1);
    if (log_err.size() != 3) check("wd_resp_count", log_err.size(), 3);
    else begin
      check("wd_err", log_err[0], 1'b1);
      check("wd_cipher_zero", log_cipher[0], '0);
      check("wd_recover_err", log_err[1], 1'b0);
      check("wd_edge_err", log_err[2], 1'b0);
    end

    // Reset mid-WAIT aborts silently and returns the pointer to 0
    req_valid  = 4'b0001;
    next_delay = 1000;
    step();
    req_valid = '0;
    for (int i = 0; i < 5; i++) step();
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_core_key", core_key, '0);
    check("mid_rst_core_data", core_data, '0);
    check("mid_rst_resp_valid", resp_valid, 1'b0);
    m_fl  = 1'b0;
    m_ptr = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    req_valid  = 4'b1001;
    next_delay = 2;
    step();
    check("post_rst_grant", grants[grants.size()-1], 0);
    drain(60);

    // Randomised traffic
    rand_mode = 1'b1;
    for (int i = 0; i < 2000; i++) step();
    rand_mode = 1'b0;
    drain(60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_req_scheduler.md
Name: aes_req_scheduler

Overview:
- Shares one iterative AES-128 encryption core between NUM_REQ independent requesters.
- Arbitrates round-robin and accepts one key/plaintext pair per grant over a valid/ready handshake.
- Sequences the core with a one-cycle start pulse, waits for done under a watchdog, and returns the ciphertext tagged with the requester ID.
- Sits between the system-side request ports and the AES top-level core.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
TIMEOUT, 15, maximum WAIT cycles before the core is declared hung.
ID_W, $clog2(NUM_REQ), width of the requester ID (derived, not overridden).

Ports:
clk  in  1  single clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
req_valid  in  NUM_REQ  per-requester request valid.
req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
req_key  in  NUM_REQ*128  bits [0:NUM_REQ*128-1]; requester i owns [i*128 +: 128], bit 0 = MSB of byte 0.
req_data  in  NUM_REQ*128  plaintext; same packing as req_key.
resp_valid  out  1  response valid.
resp_ready  in  1  response accept.
resp_id  out  ID_W  requester index of the response.
resp_cipher  out  [0:127]  ciphertext.
resp_err  out  1  1 = watchdog expired; resp_cipher is 0.
core_start  out  1  one-cycle start pulse to the AES core.
core_key  out  [0:127]  key to the core, stable from ISSUE until RESP.
core_data  out  [0:127]  plaintext to the core, stable from ISSUE until RESP.
core_done  in  1  core completion flag.
core_cipher  in  [0:127]  core output, valid while core_done = 1.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous): state IDLE, rr pointer 0, watchdog 0, all registered outputs 0 (resp_*, core_*, busy).
- req_ready is combinational and therefore 0 while req_valid is 0. Requesters keep req_valid low during reset.
- Reset mid-operation aborts the transaction with no response; the core shares reset_n.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i], scanning ptr, ptr+1, ... modulo NUM_REQ.
  - req_ready[winner] = 1 in the same cycle.
  - On the handshake: latch key, data and ID; ptr <= (winner+1) mod NUM_REQ; go to ISSUE.
  - No valid request: stay in IDLE.
  - Valid may drop before ready; arbitration is re-evaluated every cycle.
- ISSUE: core_start = 1 for exactly this cycle; core_key/core_data driven from the latches; watchdog cleared; go to WAIT.
- WAIT:
  - core_done is sampled only in this state (ignored in ISSUE, RESP and IDLE).
  - core_done = 1: resp_cipher <= core_cipher, resp_err <= 0, go to RESP.
  - Else if watchdog == TIMEOUT: resp_cipher <= 0, resp_err <= 1, go to RESP.
  - Else watchdog += 1.
  - core_done and watchdog == TIMEOUT in the same cycle: done wins, resp_err = 0.
- RESP:
  - resp_valid = 1; resp_id, resp_cipher and resp_err held stable until resp_ready.
  - req_ready stays all-zero and core_start stays 0.
  - On resp_ready: resp_valid <= 0, go to IDLE.
- Latency: accept at cycle T, core_start at T+1, WAIT from T+2. resp_valid is asserted in the cycle after done is sampled at C. With resp_ready held high, the next request can be accepted in the cycle after the response handshake completes.
- Watchdog width: $clog2(TIMEOUT+1). It never wraps; it saturates at TIMEOUT.
- Only one transaction is in flight; there is no queue beyond the requester handshake.

Decomposition:
- Shared package aes_pkg: AES_BLOCK_W = 128, AES_KEY_W = 128, enum sched_state_t {IDLE, ISSUE, WAIT, RESP}.
- One sub-module, aes_rr_pick: combinational round-robin picker. Inputs: req_valid and ptr. Outputs: winner one-hot, winner index, any_valid.
- The FSM, latches and watchdog stay in aes_req_scheduler.

Test Plan:
- Single request on requester 2 (FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, data 3243f6a8885a308d313198a2e0370734), real core, resp_ready = 1 -> core_start pulses once, 1 cycle after accept; resp_id = 2, resp_cipher = 3925841d02dc09fbdc118597196a0b32, resp_err = 0.
- All 4 requesters valid continuously, resp_ready = 1 -> grants in order 0,1,2,3,0. Then only requesters 1 and 3 valid after a grant to 1 -> next grant 3.
- resp_ready held low for 5 cycles in RESP -> resp_valid, resp_id and resp_cipher stable; req_ready = 0; core_start = 0; IDLE reached 1 cycle after resp_ready rises.
- Stub core never asserts done -> resp_valid with resp_err = 1 and resp_cipher = 0 after TIMEOUT+1 WAIT cycles (16 at default); the following request completes normally.
- Stub core asserts done in the WAIT cycle where the watchdog equals TIMEOUT -> resp_err = 0 and resp_cipher = stub value.
- reset_n pulsed low mid-WAIT -> outputs 0 immediately, no response issued; after release with requesters 0 and 3 valid -> requester 0 granted first.
